rvfpm: RTL and testbench

- Single-precision RISC-V floating-point unit model with its own FP register file.
- Accepts one instruction per clock when enabled and executes FP loads/stores, FADD.S/FSUB.S and FMV moves.
- All instructions pass through an in-order fixed-latency pipeline.
- Sits beside the integer core: memory data comes in through data_fromMem, store data goes out on data_toMem, and moves to/from integer registers use data_toXreg/data_fromXreg.

---
 rtl/rvfpm_pkg.sv | 70 +++++++
 rtl/rvfpm_fadd.sv | 87 ++++++++
 rtl/rvfpm.sv | 139 +++++++++++++
 tb/tb_rvfpm.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rvfpm_pkg.sv
// Shared encodings, op enum, pipeline entry type and instruction decode for the rvfpm FPU.
package rvfpm_pkg;

  localparam logic [6:0] OPC_LOAD_FP  = 7'b0000111;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE_FP = 7'b0100111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_FP    = 7'b1010011;

  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [2:0] F3_FMV  = 3'b000;

  localparam logic [6:0] F7_FADD  = 7'b0000000;
  localparam logic [6:0] F7_FSUB  = 7'b0000100;
  localparam logic [6:0] F7_FMVXW = 7'b1110000;
  localparam logic [6:0] F7_FMVWX = 7'b1111000;

  localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

  // Widest supported instruction tag; narrower tags are zero-extended into the entry.
  localparam int unsigned ID_MAX_WIDTH = 16;

  typedef enum logic [2:0] {
    OP_NOP,
    OP_FLW,
    OP_FSW,
    OP_FADD,
    OP_FSUB,
    OP_FMVXW,
    OP_FMVWX
  } fp_op_e;

  typedef struct packed {
    logic                    valid;
    fp_op_e                  op;
    logic [4:0]              rd;
    logic [ID_MAX_WIDTH-1:0] id;
    logic [31:0]             result;
  } pipe_entry_t;

  function automatic fp_op_e decode_op(input logic [31:0] instr);
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    fp_op_e     op;
    opc = instr[6:0];
    f3  = instr[14:12];
    f7  = instr[31:25];
    op  = OP_NOP;
    if ((opc == OPC_LOAD_FP || opc == OPC_LOAD) && f3 == F3_WORD) begin
      op = OP_FLW;
    end else if ((opc == OPC_STORE_FP || opc == OPC_STORE) && f3 == F3_WORD) begin
      op = OP_FSW;
    end else if (opc == OPC_OP_FP) begin
      case (f7)
        F7_FADD:  op = OP_FADD;
        F7_FSUB:  op = OP_FSUB;
        F7_FMVXW: op = (f3 == F3_FMV) ? OP_FMVXW : OP_NOP;
        F7_FMVWX: op = OP_FMVWX;
        default:  op = OP_NOP;
      endcase
    end
    return op;
  endfunction

  function automatic logic writes_rf(input fp_op_e op);
    return (op == OP_FLW) || (op == OP_FADD) || (op == OP_FSUB) || (op == OP_FMVWX);
  endfunction

endpackage

// File: rtl/rvfpm_fadd.sv
// Combinational binary32 add/subtract: round-to-nearest-even, subnormals flushed to signed zero.
module rvfpm_fadd
  import rvfpm_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        sub,
  output logic [31:0] y
);

  logic               sa, sb, sx, sy;
  logic [7:0]         ea, eb, ex, ey, d;
  logic [22:0]        ma, mb, mx, my, frac;
  logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [4:0]         dsh, lz;
  logic [49:0]        big;
  logic [26:0]        fx, fy, norm;
  logic [27:0]        sum;
  logic signed [9:0]  e, e2;
  logic               up;
  logic [24:0]        rnd;

  always_comb begin
    sa = a[31];
    ea = a[30:23];
    ma = a[22:0];
    sb = b[31] ^ sub;
    eb = b[30:23];
    mb = b[22:0];

    a_nan  = (ea == 8'hFF) && (ma != '0);
    b_nan  = (eb == 8'hFF) && (mb != '0);
    a_inf  = (ea == 8'hFF) && (ma == '0);
    b_inf  = (eb == 8'hFF) && (mb == '0);
    a_zero = (ea == 8'h00);
    b_zero = (eb == 8'h00);

    if ({eb, mb} > {ea, ma}) begin
      sx = sb; ex = eb; mx = mb;
      sy = sa; ey = ea; my = ma;
    end else begin
      sx = sa; ex = ea; mx = ma;
      sy = sb; ey = eb; my = mb;
    end

    // Shifts beyond 30 leave the hidden bit inside the sticky window, so capping is exact.
    d   = ex - ey;
    dsh = (d > 8'd30) ? 5'd30 : d[4:0];
    big = {1'b1, my, 26'b0} >> dsh;
    fy  = {big[49:24], |big[23:0]};
    fx  = {1'b1, mx, 3'b000};

    if (sx == sy) sum = {1'b0, fx} + {1'b0, fy};
    else          sum = {1'b0, fx} - {1'b0, fy};

    lz = '0;
    for (int unsigned i = 0; i < 27; i++) begin
      if (sum[i]) lz = 5'(26 - i);
    end

    if (sum[27]) begin
      norm = {sum[27:2], sum[1] | sum[0]};
      e    = signed'({2'b00, ex}) + 10'sd1;
    end else begin
      norm = sum[26:0] << lz;
      e    = signed'({2'b00, ex}) - signed'({5'b00000, lz});
    end

    up   = norm[2] & (norm[1] | norm[0] | norm[3]);
    rnd  = {1'b0, norm[26:3]} + {24'b0, up};
    e2   = rnd[24] ? (e + 10'sd1) : e;
    frac = rnd[24] ? '0 : rnd[22:0];

    y = '0;
    if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) y = CANON_NAN;
    else if (a_inf)                                       y = {sa, 8'hFF, 23'b0};
    else if (b_inf)                                       y = {sb, 8'hFF, 23'b0};
    else if (a_zero && b_zero)                            y = {sa & sb, 31'b0};
    else if (a_zero)                                      y = {sb, eb, mb};
    else if (b_zero)                                      y = {sa, ea, ma};
    else if (sum == '0)                                   y = '0;
    else if (e2 >= 10'sd255)                              y = {sx, 8'hFF, 23'b0};
    else if (e2 <= 10'sd0)                                y = {sx, 31'b0};
    else                                                  y = {sx, e2[7:0], frac};
  end

endmodule

// File: rtl/rvfpm.sv
// Single-precision RISC-V FPU model: FP register file plus fixed-latency in-order pipeline.
module rvfpm
  import rvfpm_pkg::*;
#(
  parameter int unsigned NUM_REGS        = 32,
  parameter int unsigned PIPELINE_STAGES = 4,
  parameter int unsigned X_ID_WIDTH      = 4,
  parameter int unsigned FLEN            = 32,
  parameter int unsigned XLEN            = 32
) (
  input  logic                  ck,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [31:0]           instruction,
  input  logic [X_ID_WIDTH-1:0] id,
  input  logic [XLEN-1:0]       data_fromXreg,
  input  logic [XLEN-1:0]       data_fromMem,
  output logic [X_ID_WIDTH-1:0] id_out,
  output logic [XLEN-1:0]       data_toXreg,
  output logic                  toXreg_valid,
  output logic [XLEN-1:0]       data_toMem,
  output logic                  toMem_valid
);

  localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  function automatic logic [IDX_W-1:0] reg_idx(input logic [4:0] r);
    return IDX_W'(32'(r) % NUM_REGS);
  endfunction

  pipe_entry_t               pipe_q [PIPELINE_STAGES];
  pipe_entry_t               pipe_d [PIPELINE_STAGES];
  logic [FLEN-1:0]           rf_q   [NUM_REGS];
  logic [FLEN-1:0]           rf_d   [NUM_REGS];
  logic [X_ID_WIDTH-1:0]     id_out_q, id_out_d;
  logic [XLEN-1:0]           data_toXreg_q, data_toXreg_d;
  logic [XLEN-1:0]           data_toMem_q, data_toMem_d;
  logic                      toXreg_valid_q, toXreg_valid_d;
  logic                      toMem_valid_q, toMem_valid_d;

  pipe_entry_t               ret, iss_entry;
  fp_op_e                    iss_op;
  logic [4:0]                iss_rd, iss_rs1, iss_rs2;
  logic [31:0]               rs1_val, rs2_val, fadd_y, iss_result;
  logic                      ret_wb;

  assign ret    = pipe_q[PIPELINE_STAGES-1];
  assign ret_wb = ret.valid && writes_rf(ret.op);

  // Operand read also sees the write retiring on this same edge.
  always_comb begin
    iss_op  = enable ? decode_op(instruction) : OP_NOP;
    iss_rd  = instruction[11:7];
    iss_rs1 = instruction[19:15];
    iss_rs2 = instruction[24:20];

    rs1_val = 32'(rf_q[reg_idx(iss_rs1)]);
    if (ret_wb && reg_idx(ret.rd) == reg_idx(iss_rs1)) rs1_val = ret.result;
    rs2_val = 32'(rf_q[reg_idx(iss_rs2)]);
    if (ret_wb && reg_idx(ret.rd) == reg_idx(iss_rs2)) rs2_val = ret.result;
  end

  rvfpm_fadd u_fadd (
    .a   (rs1_val),
    .b   (rs2_val),
    .sub (iss_op == OP_FSUB),
    .y   (fadd_y)
  );

  always_comb begin
    case (iss_op)
      OP_FLW:           iss_result = 32'(data_fromMem);
      OP_FMVWX:         iss_result = 32'(data_fromXreg);
      OP_FSW:           iss_result = rs2_val;
      OP_FMVXW:         iss_result = rs1_val;
      OP_FADD, OP_FSUB: iss_result = fadd_y;
      default:          iss_result = '0;
    endcase

    iss_entry        = '0;
    iss_entry.valid  = (iss_op != OP_NOP);
    iss_entry.op     = iss_op;
    iss_entry.rd     = iss_rd;
    iss_entry.id     = ID_MAX_WIDTH'(id);
    iss_entry.result = iss_result;

    pipe_d[0] = iss_entry;
    for (int unsigned i = 1; i < PIPELINE_STAGES; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end

    rf_d = rf_q;
    if (ret_wb) rf_d[reg_idx(ret.rd)] = FLEN'(ret.result);

    id_out_d       = id_out_q;
    data_toXreg_d  = data_toXreg_q;
    data_toMem_d   = data_toMem_q;
    toXreg_valid_d = 1'b0;
    toMem_valid_d  = 1'b0;
    if (ret.valid) begin
      id_out_d = X_ID_WIDTH'(ret.id);
      if (ret.op == OP_FSW) begin
        data_toMem_d  = XLEN'(ret.result);
        toMem_valid_d = 1'b1;
      end
      if (ret.op == OP_FMVXW) begin
        data_toXreg_d  = XLEN'(ret.result);
        toXreg_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < PIPELINE_STAGES; i++) pipe_q[i] <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++)        rf_q[i]   <= '0;
      id_out_q       <= '0;
      data_toXreg_q  <= '0;
      data_toMem_q   <= '0;
      toXreg_valid_q <= 1'b0;
      toMem_valid_q  <= 1'b0;
    end else begin
      pipe_q         <= pipe_d;
      rf_q           <= rf_d;
      id_out_q       <= id_out_d;
      data_toXreg_q  <= data_toXreg_d;
      data_toMem_q   <= data_toMem_d;
      toXreg_valid_q <= toXreg_valid_d;
      toMem_valid_q  <= toMem_valid_d;
    end
  end

  assign id_out       = id_out_q;
  assign data_toXreg  = data_toXreg_q;
  assign toXreg_valid = toXreg_valid_q;
  assign data_toMem   = data_toMem_q;
  assign toMem_valid  = toMem_valid_q;

endmodule

// File: tb/tb_rvfpm.sv
// Self-checking bench for rvfpm: directed cases plus random FADD/FSUB against a real-arithmetic model.
module tb_rvfpm;

  localparam int unsigned P = 4;

  logic        ck, rst, enable;
  logic [31:0] instruction;
  logic [3:0]  id;
  logic [31:0] data_fromXreg, data_fromMem;
  logic [3:0]  id_out;
  logic [31:0] data_toXreg, data_toMem;
  logic        toXreg_valid, toMem_valid;

  rvfpm #(
    .NUM_REGS        (32),
    .PIPELINE_STAGES (P),
    .X_ID_WIDTH      (4),
    .FLEN            (32),
    .XLEN            (32)
  ) dut (
    .ck            (ck),
    .rst           (rst),
    .enable        (enable),
    .instruction   (instruction),
    .id            (id),
    .data_fromXreg (data_fromXreg),
    .data_fromMem  (data_fromMem),
    .id_out        (id_out),
    .data_toXreg   (data_toXreg),
    .toXreg_valid  (toXreg_valid),
    .data_toMem    (data_toMem),
    .toMem_valid   (toMem_valid)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  int unsigned cyc = 0;
  always @(posedge ck) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected retire events: kind 0 = writeback only, 1 = store data, 2 = move to integer reg.
  typedef struct {
    int unsigned vis_cyc;
    int          kind;
    logic [31:0] data;
    logic [3:0]  tag;
  } exp_t;

  exp_t        q[$];
  exp_t        cur;
  logic [31:0] mrf [32];
  logic [3:0]  exp_id;
  logic [31:0] exp_mem, exp_x;
  logic        exp_mv, exp_xv;

  always @(posedge ck) begin
    #1;
    exp_mv = 1'b0;
    exp_xv = 1'b0;
    if (q.size() != 0 && q[0].vis_cyc == cyc) begin
      cur    = q.pop_front();
      exp_id = cur.tag;
      if (cur.kind == 1) begin exp_mem = cur.data; exp_mv = 1'b1; end
      if (cur.kind == 2) begin exp_x   = cur.data; exp_xv = 1'b1; end
    end
    check_eq("toMem_valid",  32'(toMem_valid),  32'(exp_mv));
    check_eq("toXreg_valid", 32'(toXreg_valid), 32'(exp_xv));
    check_eq("id_out",       32'(id_out),       32'(exp_id));
    check_eq("data_toMem",   data_toMem,        exp_mem);
    check_eq("data_toXreg",  data_toXreg,       exp_x);
  end

  // Reference: exact double sum rounded once to binary32 (double rounding is innocuous for addition).
  function automatic real f32_to_real(input logic [31:0] f);
    if (f[30:23] == 8'h00) return $bitstoreal({f[31], 63'b0});
    return $bitstoreal({f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'b0});
  endfunction

  function automatic logic [31:0] real_to_f32(input real s);
    logic [63:0] d;
    logic [52:0] m;
    logic [23:0] keep;
    logic [28:0] rem;
    logic [24:0] k25;
    logic [22:0] frac;
    int          fe;
    d = $realtobits(s);
    if (d[62:0] == '0) return {d[63], 31'b0};
    m    = {1'b1, d[51:0]};
    keep = m[52:29];
    rem  = m[28:0];
    k25  = {1'b0, keep};
    if (rem > 29'h1000_0000 || (rem == 29'h1000_0000 && keep[0])) k25 = k25 + 25'd1;
    fe   = int'(d[62:52]) - 896;
    frac = k25[22:0];
    if (k25[24]) begin fe++; frac = '0; end
    if (fe >= 255) return {d[63], 8'hFF, 23'b0};
    if (fe <= 0)   return {d[63], 31'b0};
    return {d[63], fe[7:0], frac};
  endfunction

  function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b, input bit sub);
    logic [31:0] bb;
    bit a_nan, b_nan, a_inf, b_inf;
    bb    = sub ? (b ^ 32'h8000_0000) : b;
    a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    b_nan = (bb[30:23] == 8'hFF) && (bb[22:0] != 0);
    a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 0);
    b_inf = (bb[30:23] == 8'hFF) && (bb[22:0] == 0);
    if (a_nan || b_nan) return 32'h7FC0_0000;
    if (a_inf && b_inf) return (a[31] == bb[31]) ? a : 32'h7FC0_0000;
    if (a_inf) return a;
    if (b_inf) return bb;
    return real_to_f32(f32_to_real(a) + f32_to_real(bb));
  endfunction

  function automatic logic [31:0] rand_fp(input logic [7:0] near, input bit use_near);
    logic [31:0] r;
    int          ne;
    r = $urandom;
    case ($urandom_range(0, 19))
      0: return {r[31], 31'b0};
      1: return {r[31], 8'hFF, 23'b0};
      2: return {r[31], 8'hFF, r[22:1], 1'b1};
      3: return {r[31], 8'h00, r[22:0]};
      4: return {r[31], 8'hFE, r[22:0]};
      default: begin
        if (use_near) ne = int'(near) + int'($urandom_range(0, 6)) - 3;
        else          ne = int'($urandom_range(1, 254));
        if (ne < 1)   ne = 1;
        if (ne > 254) ne = 254;
        return {r[31], ne[7:0], r[22:0]};
      end
    endcase
  endfunction

  task automatic drive(input logic en, input logic [31:0] ins, input logic [3:0] tag,
                       input logic [31:0] mem, input logic [31:0] x);
    @(negedge ck);
    enable        = en;
    instruction   = ins;
    id            = tag;
    data_fromMem  = mem;
    data_fromXreg = x;
  endtask

  task automatic push_exp(input int kind, input logic [31:0] data, input logic [3:0] tag);
    exp_t e;
    e.vis_cyc = cyc + 1 + P;
    e.kind    = kind;
    e.data    = data;
    e.tag     = tag;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, $urandom, 4'($urandom), $urandom, $urandom);
  endtask

  task automatic flw(input logic [4:0] rd, input logic [31:0] v, input logic [3:0] tag);
    logic [6:0] opc;
    opc = $urandom_range(0, 1) ? 7'b0000111 : 7'b0000011;
    drive(1'b1, {12'($urandom), 5'($urandom), 3'b010, rd, opc}, tag, v, $urandom);
    mrf[rd] = v;
    push_exp(0, 32'h0, tag);
  endtask

  task automatic fsw(input logic [4:0] rs2, input logic [3:0] tag);
    logic [6:0] opc;
    opc = $urandom_range(0, 1) ? 7'b0100111 : 7'b0100011;
    drive(1'b1, {7'($urandom), rs2, 5'($urandom), 3'b010, 5'($urandom), opc}, tag, $urandom, $urandom);
    push_exp(1, mrf[rs2], tag);
  endtask

  task automatic fop(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                     input bit sub, input logic [3:0] tag, input logic [31:0] expv);
    drive(1'b1, {sub ? 7'b0000100 : 7'b0000000, rs2, rs1, 3'($urandom), rd, 7'b1010011},
          tag, $urandom, $urandom);
    mrf[rd] = expv;
    push_exp(0, 32'h0, tag);
  endtask

  task automatic fmvwx(input logic [4:0] rd, input logic [31:0] x, input logic [3:0] tag);
    drive(1'b1, {7'b1111000, 5'd0, 5'd0, 3'b000, rd, 7'b1010011}, tag, $urandom, x);
    mrf[rd] = x;
    push_exp(0, 32'h0, tag);
  endtask

  task automatic fmvxw(input logic [4:0] rs1, input logic [3:0] tag);
    drive(1'b1, {7'b1110000, 5'd0, rs1, 3'b000, 5'($urandom), 7'b1010011}, tag, $urandom, $urandom);
    push_exp(2, mrf[rs1], tag);
  endtask

  task automatic binop_case(input logic [31:0] a, input logic [31:0] b, input bit sub,
                            input logic [31:0] expv);
    flw(5'd6, a, 4'd10);
    flw(5'd7, b, 4'd11);
    idle(P - 1);
    fop(5'd8, 5'd6, 5'd7, sub, 4'd12, expv);
    idle(P - 1);
    fsw(5'd8, 4'd13);
  endtask

  task automatic clear_model();
    q.delete();
    for (int i = 0; i < 32; i++) mrf[i] = '0;
    exp_id  = '0;
    exp_mem = '0;
    exp_x   = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [4:0]  r1, r2, r3;
    logic [31:0] a, b;
    bit          sub;

    rst = 1'b0;
    enable = 1'b0;
    instruction = '0;
    id = '0;
    data_fromMem = '0;
    data_fromXreg = '0;
    clear_model();
    repeat (3) @(negedge ck);
    rst = 1'b1;
    idle(2);

    // FLW/FSW round-trip, FSW issued on the retire edge of the FLW.
    flw(5'd1, 32'h3F80_0000, 4'd1);
    idle(P - 1);
    drive(1'b1, 32'h0010_2023, 4'd2, $urandom, $urandom);
    push_exp(1, 32'h3F80_0000, 4'd2);
    idle(P);

    // FADD f3,f1,f2 with the instruction word from the ISA encoding.
    flw(5'd1, 32'h3F80_0000, 4'd3);
    flw(5'd2, 32'h4120_28F6, 4'd4);
    idle(P - 1);
    drive(1'b1, 32'h0020_81D3, 4'd5, $urandom, $urandom);
    mrf[3] = 32'h4130_28F6;
    push_exp(0, 32'h0, 4'd5);
    idle(P - 1);
    fsw(5'd3, 4'd6);
    idle(P);

    binop_case(32'h3F80_0000, 32'h3F80_0000, 1'b1, 32'h0000_0000);
    binop_case(32'h7F80_0000, 32'hFF80_0000, 1'b0, 32'h7FC0_0000);
    binop_case(32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F80_0000);
    binop_case(32'h0000_0001, 32'h8000_0000, 1'b0, 32'h0000_0000);
    binop_case(32'h3F80_0000, 32'h3380_0000, 1'b0, 32'h3F80_0000);
    binop_case(32'h3F80_0000, 32'h3380_0001, 1'b0, 32'h3F80_0001);
    idle(P);

    // Moves through the integer side.
    fmvwx(5'd4, 32'hC049_0FDB, 4'd7);
    idle(P - 1);
    fmvxw(5'd4, 4'd8);
    idle(P);

    // Four back-to-back loads, then read each back.
    for (int i = 0; i < 4; i++) flw(5'(10 + i), $urandom, 4'(i + 1));
    idle(P - 1);
    for (int i = 0; i < 4; i++) fsw(5'(10 + i), 4'(i + 9));
    idle(P);

    // Gated and unrecognised issues must leave f9 and the outputs untouched.
    flw(5'd9, 32'h1234_5678, 4'd3);
    idle(P);
    drive(1'b0, {12'h0, 5'd0, 3'b010, 5'd9, 7'b0000111}, 4'd14, 32'hDEAD_BEEF, $urandom);
    drive(1'b1, 32'h0000_0000, 4'd15, 32'hDEAD_BEEF, $urandom);
    drive(1'b1, {7'b0001000, 5'd1, 5'd2, 3'b000, 5'd9, 7'b1010011}, 4'd15, $urandom, $urandom);
    drive(1'b1, {7'b1110000, 5'd0, 5'd9, 3'b001, 5'd1, 7'b1010011}, 4'd15, $urandom, $urandom);
    drive(1'b1, {12'h0, 5'd0, 3'b011, 5'd9, 7'b0000111}, 4'd15, 32'hDEAD_BEEF, $urandom);
    idle(P + 1);
    fsw(5'd9, 4'd2);
    idle(P);

    for (int t = 0; t < 150; t++) begin
      r1  = 5'($urandom);
      r2  = r1 ^ 5'($urandom_range(1, 31));
      r3  = 5'($urandom);
      sub = bit'($urandom_range(0, 1));
      a   = rand_fp(8'd0, 1'b0);
      b   = rand_fp(a[30:23], 1'b1);
      if ($urandom_range(0, 7) == 0) b = sub ? a : (a ^ 32'h8000_0000);
      flw(r1, a, 4'($urandom));
      flw(r2, b, 4'($urandom));
      idle(P - 1);
      fop(r3, r1, r2, sub, 4'($urandom), ref_add(a, b, sub));
      idle(P - 1);
      if ($urandom_range(0, 1) == 1) fsw(r3, 4'($urandom));
      else                           fmvxw(r3, 4'($urandom));
      idle(int'($urandom_range(0, 2)));
    end
    idle(P + 1);

    // Reset mid-run with an FLW to f5 still in flight.
    flw(5'd5, 32'h4040_0000, 4'd6);
    idle(P - 1);
    fsw(5'd5, 4'd9);
    idle(P);
    flw(5'd5, 32'hAAAA_5555, 4'd4);
    @(negedge ck);
    enable = 1'b0;
    #1;
    rst = 1'b0;
    clear_model();
    #1;
    check_eq("rst_toMem_valid",  32'(toMem_valid),  32'h0);
    check_eq("rst_toXreg_valid", 32'(toXreg_valid), 32'h0);
    check_eq("rst_id_out",       32'(id_out),       32'h0);
    check_eq("rst_data_toMem",   data_toMem,        32'h0);
    check_eq("rst_data_toXreg",  data_toXreg,       32'h0);
    repeat (2) @(negedge ck);
    rst = 1'b1;
    idle(P + 1);
    fsw(5'd5, 4'd7);
    idle(P + 2);

    check_eq("queue_drained", 32'(q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
